apb_mst_bridge: RTL and testbench
=================================

Name: apb_mst_bridge

Overview:
- RTL APB4 requester: the master end of the APB bus whose slave side our VIP models.
- Accepts single read/write commands on a valid/ready command port and runs the APB SETUP/ACCESS sequence.
- Waits on PREADY with a bounded timeout, then returns read data and status on a valid/ready response port.
- Sits between the SoC-side register-access fabric and APB peripherals; the VIP slave agent is its test partner.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr
- DATA_WIDTH, 32, width of PWDATA/PRDATA; must be 8, 16 or 32
- STRB_WIDTH, DATA_WIDTH/8, width of PSTROB and cmd_strb
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
- clk  input  1  clock; all logic is on the rising edge
- rstn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  bridge accepts a command
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- cmd_strb  input  STRB_WIDTH  write byte strobes
- cmd_prot  input  3  protection attributes
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and on timeout
- rsp_slverr  output  1  PSLVERR captured, or timeout
- rsp_timeout  output  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  output  1 each  APB controls
- PADDR  output  ADDR_WIDTH  APB address
- PWDATA  output  DATA_WIDTH  APB write data
- PSTROB  output  STRB_WIDTH  APB write strobes
- PPROT  output  3  APB protection
- PRDATA  input  DATA_WIDTH  APB read data
- PREADY  input  1  slave ready
- PSLVERR  input  1  slave error

Behaviour:
- Reset (async assert, sync deassert):
  - Every output goes to 0 immediately, including cmd_ready.
  - FSM enters IDLE and the wait counter clears.
  - A transfer in flight is dropped with no response.
- All APB outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready=1, PSEL=0. On cmd_valid, capture the command into the APB registers and go to SETUP. For reads, PSTROB is forced to 0 and PWDATA to 0.
  - SETUP: exactly one cycle, PSEL=1, PENABLE=0, cmd_ready=0. Then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; address, control and data are held stable.
    - PREADY=1 at the clock edge: capture PRDATA (reads only) and PSLVERR, drop PSEL/PENABLE, go to RESP.
    - PREADY=0: increment the wait counter.
    - Abort when TIMEOUT!=0, PREADY=0 and the wait counter reaches TIMEOUT-1: drop PSEL/PENABLE, set rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
    - If PREADY=1 on the abort cycle, PREADY wins and the transfer completes normally.
  - RESP: rsp_valid=1; response fields held stable until rsp_valid & rsp_ready, then go to IDLE and clear rsp_valid.
- Latency:
  - Accept at cycle N; SETUP at N+1; ACCESS at N+2.
  - With zero wait states, rsp_valid is 1 at N+3.
  - The earliest next accept is the cycle after the handshake: one transfer outstanding, no pipelining.
- PADDR is passed through unaligned; no address decode or error is generated by the bridge.
- PSLVERR is sampled only when PREADY=1 in ACCESS; it is ignored otherwise.
- The wait counter width is clog2(TIMEOUT+1). It clears on entry to ACCESS and never wraps.

Decomposition:
- apb_mst_pkg holds:
  - the FSM state enum
  - cmd/rsp packed struct typedefs
  - PPROT bit constants (privileged, non-secure, instruction)
  - the default width constants, aligned with the existing APB width macros
- One sub-module, apb_mst_wait_timer: wait counter plus timeout compare, with a clear/enable/expired interface. Everything else stays in apb_mst_bridge.

Test Plan:
- Write, zero wait: cmd addr=0x10, wdata=0xDEADBEEF, strb=0xF -> SETUP at N+1, ACCESS at N+2 with PSTROB=0xF; rsp_valid at N+3, rsp_slverr=0.
- Read, 3 wait states: slave PRDATA=0xA5A5_0001 with PREADY high on the 4th ACCESS cycle -> rsp_rdata=0xA5A50001, PADDR/PWRITE stable through all ACCESS cycles, PSTROB=0.
- Slave error: write with PSLVERR=1 and PREADY=1 -> rsp_slverr=1, rsp_timeout=0.
- Timeout: TIMEOUT=16, PREADY held low -> PSEL drops after 16 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY rising exactly on cycle 16 -> normal completion.
- Response backpressure: rsp_ready low for 5 cycles -> rsp fields stable, cmd_ready=0, no new SETUP. Back-to-back commands are accepted one per response.
- Reset mid-ACCESS: rstn low during a wait state -> PSEL/PENABLE/rsp_valid are 0 immediately; after release, the bridge is in IDLE with cmd_ready=1 and no stale response.

Source files
------------

// File: rtl/apb_mst_pkg.sv
// Shared types and constants for the APB4 requester bridge.
// The default widths follow the APB width macros when the build defines them.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_mst_pkg;

  localparam int APB_ADDR_W      = `APB_ADDR_WIDTH;
  localparam int APB_DATA_W      = `APB_DATA_WIDTH;
  localparam int APB_STRB_W      = APB_DATA_W / 8;
  localparam int APB_TIMEOUT_DEF = 16;

  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [2:0]            prot;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_mst_wait_timer.sv
// Counts ACCESS cycles with PREADY low; flags expiry on the last allowed wait cycle.
module apb_mst_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] count;

  // Saturates instead of wrapping so a stuck slave can never re-arm the compare.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT > 0) && (count == LIMIT);

endmodule

// File: rtl/apb_mst_bridge.sv
// APB4 requester: one command in, one SETUP/ACCESS transfer out, one response back.
module apb_mst_bridge
  import apb_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = APB_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTROB,
  output logic [2:0]            PPROT,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e state;
  logic       timer_clear;
  logic       timer_en;
  logic       timer_expired;

  assign timer_clear = (state == ST_SETUP);
  assign timer_en    = (state == ST_ACCESS) && !PREADY;

  apb_mst_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // cmd_ready is registered so it reads 0 throughout reset and rises one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTROB      <= '0;
      PPROT       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_write ? cmd_wdata : '0;
            PSTROB    <= cmd_write ? cmd_strb : '0;
            PPROT     <= cmd_prot;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A ready slave on the final wait cycle beats the timeout.
          if (PREADY) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_slverr  <= PSLVERR;
            rsp_timeout <= 1'b0;
            state       <= ST_RESP;
          end else if (timer_expired) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Directed plus randomized bench for apb_mst_bridge; the bench plays the APB slave
// and predicts each response from the transfer's wait count and slave reply.
module tb_apb_mst_bridge;
  import apb_mst_pkg::*;

  localparam int TIMEOUT_P = 16;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTROB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_mst_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .STRB_WIDTH (4),
    .TIMEOUT    (TIMEOUT_P)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTROB      (PSTROB),
    .PPROT       (PPROT),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } exp_t;

  // Expected outcome of one transfer: how many ACCESS cycles it lasts and what it returns.
  function automatic exp_t refModel(input bit write, input int waits,
                                    input logic [31:0] prdata, input bit pslverr);
    exp_t e;
    if (TIMEOUT_P != 0 && waits >= TIMEOUT_P) begin
      e.cycles  = TIMEOUT_P;
      e.rdata   = 32'h0;
      e.slverr  = 1'b1;
      e.timeout = 1'b1;
    end else begin
      e.cycles  = waits + 1;
      e.rdata   = write ? 32'h0 : prdata;
      e.slverr  = pslverr;
      e.timeout = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit write, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [2:0] prot);
    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
  endtask

  task automatic doTransfer(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot, input int waits,
                            input logic [31:0] prdata, input bit pslverr, input int holdCycles);
    exp_t e;
    int   guard;
    e = refModel(write, waits, prdata, pslverr);
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    applyStimulus(write, addr, wdata, strb, prot);
    tick();
    cmd_valid = 1'b0;
    checkOutput("setup_psel", PSEL, 1);
    checkOutput("setup_penable", PENABLE, 0);
    checkOutput("setup_cmd_ready", cmd_ready, 0);
    tick();
    for (int k = 0; k < e.cycles; k++) begin
      checkOutput("access_psel", PSEL, 1);
      checkOutput("access_penable", PENABLE, 1);
      checkOutput("access_paddr", PADDR, addr);
      checkOutput("access_pwrite", PWRITE, write);
      checkOutput("access_pwdata", PWDATA, write ? wdata : 32'h0);
      checkOutput("access_pstrob", PSTROB, write ? strb : 4'h0);
      checkOutput("access_pprot", PPROT, prot);
      checkOutput("access_rsp_valid", rsp_valid, 0);
      PREADY  = (k == waits);
      PRDATA  = (k == waits) ? prdata : $urandom;
      PSLVERR = (k == waits) ? pslverr : 1'($urandom_range(0, 1));
      tick();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = $urandom;
    checkOutput("resp_valid", rsp_valid, 1);
    checkOutput("resp_psel", PSEL, 0);
    checkOutput("resp_penable", PENABLE, 0);
    checkOutput("resp_rdata", rsp_rdata, e.rdata);
    checkOutput("resp_slverr", rsp_slverr, e.slverr);
    checkOutput("resp_timeout", rsp_timeout, e.timeout);
    if (holdCycles > 0) applyStimulus(1'b1, 32'hFFFF_FFF0, 32'h1234_5678, 4'h3, 3'h0);
    for (int h = 0; h < holdCycles; h++) begin
      tick();
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_rdata", rsp_rdata, e.rdata);
      checkOutput("hold_rsp_slverr", rsp_slverr, e.slverr);
      checkOutput("hold_cmd_ready", cmd_ready, 0);
      checkOutput("hold_psel", PSEL, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("done_rsp_valid", rsp_valid, 0);
    checkOutput("done_cmd_ready", cmd_ready, 1);
    checkOutput("done_psel", PSEL, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          waits;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    #2;
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    checkOutput("reset_psel", PSEL, 0);
    checkOutput("reset_penable", PENABLE, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_paddr", PADDR, 0);
    checkOutput("reset_pwdata", PWDATA, 0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    tick();
    checkOutput("post_reset_cmd_ready", cmd_ready, 1);
    checkOutput("post_reset_psel", PSEL, 0);

    $display("[TB] write, zero wait");
    doTransfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, PPROT_PRIV, 0, 32'h0, 1'b0, 0);
    $display("[TB] read, three wait states");
    doTransfer(1'b0, 32'h0000_0024, 32'h5555_5555, 4'hF, PPROT_NONSEC | PPROT_INSTR, 3,
               32'hA5A5_0001, 1'b0, 0);
    $display("[TB] slave error on write");
    doTransfer(1'b1, 32'h0000_0103, 32'h0BAD_F00D, 4'h6, 3'h0, 0, 32'h0, 1'b1, 0);
    $display("[TB] timeout with PREADY held low");
    doTransfer(1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'h0, TIMEOUT_P, 32'hCAFE_0000, 1'b0, 0);
    $display("[TB] PREADY on the last allowed cycle");
    doTransfer(1'b0, 32'h0000_0204, 32'h0, 4'h0, 3'h0, TIMEOUT_P - 1, 32'h1357_9BDF, 1'b0, 0);
    $display("[TB] response backpressure with a pending command");
    doTransfer(1'b0, 32'h0000_0300, 32'h0, 4'h0, PPROT_PRIV, 1, 32'h0F0F_1234, 1'b1, 5);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 24; t++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      waits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TIMEOUT_P - 2, TIMEOUT_P + 1))
                                          : int'($urandom_range(0, 4));
      doTransfer(wr, addr, wdata, 4'($urandom), 3'($urandom), waits, rdata,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("[TB] reset during a wait state");
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    PREADY = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_access", PENABLE, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("midreset_psel", PSEL, 0);
    checkOutput("midreset_penable", PENABLE, 0);
    checkOutput("midreset_rsp_valid", rsp_valid, 0);
    checkOutput("midreset_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checkOutput("after_reset_cmd_ready", cmd_ready, 1);
    checkOutput("after_reset_psel", PSEL, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("after_reset_no_rsp", rsp_valid, 0);
    end
    doTransfer(1'b1, 32'h0000_0044, 32'h7777_8888, 4'hC, 3'h0, 2, 32'h0, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
